determinant_seq: RTL
====================

# determinant_seq

Sequential, parametrised determinant engine for 2x2 and 3x3 integer matrices. It accepts a matrix through a valid/ready handshake and evaluates the Leibniz expansion one signed triple product per cycle on a single shared multiplier. It returns a full-width two's-complement result through a second valid/ready handshake. It sits in the matrix-arithmetic datapath as the clocked, wider, multi-size successor to the combinational 2x2 determinant.

## Interface
- W, 2: element width in bits.
- SIGNED, 0: 0 means elements are unsigned; 1 means elements are two's complement.
- DW, 3*W+3: result width (derived; do not override).
- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- in_valid  in  1: matrix and mode are presented.
- in_ready  out  1: engine can accept a matrix.
- mode  in  1: 0 selects 2x2, 1 selects 3x3; sampled at accept.
- mat_in  in  9*W: row-major; element m[r][c] is at bits [(3r+c)*W +: W]. In 2x2 mode only m00, m01, m10 and m11 are used; the rest are ignored.
- out_valid  out  1: det holds a finished result.
- out_ready  in  1: consumer takes the result.
- det  out  DW: signed determinant.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture mat_in and mode, clear the accumulator, set term index k=0, and go to CALC.
  - CALC: each cycle, acc += sign[k]·x[k]·y[k]·z[k] and k++. After the last term, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Term schedule for 3x3, N=6, in order k=0..5:
  - +m00·m11·m22
  - +m01·m12·m20
  - +m02·m10·m21
  - −m02·m11·m20
  - −m00·m12·m21
  - −m01·m10·m22
- Term schedule for 2x2, N=2: +m00·m11·1, then −m01·m10·1. The third factor is the constant 1, so the multiplier datapath is the same for both sizes.
- Arithmetic:
  - Operands are extended to DW before multiplying: zero-extended if SIGNED=0, sign-extended if SIGNED=1.
  - Accumulation is exact in DW bits; no overflow is possible for any input.
  - Bounds: |det| ≤ 3·(2^W−1)^3 when unsigned; |det| ≤ 6·2^(3W−3) when signed.
- In IDLE, in_valid=0 is a no-op.
- While in CALC or DONE, in_valid is ignored and mat_in may change freely.
- det is the accumulator register. It is valid only while out_valid=1. It holds the last result in IDLE and changes during CALC.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, det=0, k=0. Reset takes effect immediately, including mid-CALC or mid-DONE. Any in-flight result is discarded and no out_valid pulse is produced.
- Accept happens at the rising edge where in_valid && in_ready.
- The N terms accumulate on the next N edges. out_valid rises after the N-th of those edges.
- Latency from the accept edge to out_valid=1 is N cycles: 2 in 2x2 mode, 6 in 3x3 mode.
- out_valid and det stay stable for as long as out_ready=0.
- A DONE→IDLE transition happens at the edge where out_valid && out_ready. in_ready is 1 in the following cycle; there is no same-cycle bypass.
- Back-to-back throughput with out_ready tied high is one result every N+2 cycles.
- in_ready and out_valid are decoded from registered state; neither depends combinationally on an input.

## Structure
- Package det_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the localparam term-index tables (x, y, z element indices and sign for each k, one table per mode);
  - the term counts N2=2 and N3=6;
  - the DW width function.
- Sub-module det_term_mul is the combinational signed triple-product unit. It takes three DW-extended operands and a sign, and returns a DW-bit term. The top level holds the FSM, the counter, the captured matrix and the accumulator.

## Test plan
- W=2, SIGNED=0, mode=0, [[3,1],[2,3]] → det=7 (9'h007). out_valid is high 2 cycles after accept.
- W=2, SIGNED=0, mode=0, [[0,3],[3,0]] → det=−9 (9'h1F7).
- W=2, SIGNED=0, mode=1, [[1,2,3],[3,2,1],[2,1,3]] → det=−12 (9'h1F4). out_valid is high 6 cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid with new data. Required: det and out_valid remain stable, in_ready=0, and the new data is not captured.
- Assert rst asynchronously 3 cycles into a 3x3 CALC. Required: out_valid=0, det=0 and in_ready=1 immediately. A following 3x3 operation on the identity matrix returns det=1.
- W=3, SIGNED=1, mode=1, all elements −4 → det=0. Then [[−4,0,0],[0,−4,0],[0,0,−4]] → det=−64 (12'hFC0). Run with out_ready tied high; the two results arrive 8 cycles apart.

Source files
------------

// File: rtl/det_pkg.sv
// Shared types, term schedules and width helper for the sequential determinant engine.
package det_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  localparam int unsigned N2 = 2;
  localparam int unsigned N3 = 6;

  // Element index 9 selects the constant 1 operand, so 2x2 terms reuse the triple multiplier.
  localparam logic [3:0] OneIdx = 4'd9;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic       neg;
  } term_t;

  // Element indices are row-major: m[r][c] -> 3r+c. Entries 6 and 7 are never reached.
  localparam term_t Term3 [8] = '{
    '{4'd0, 4'd4, 4'd8, 1'b0},
    '{4'd1, 4'd5, 4'd6, 1'b0},
    '{4'd2, 4'd3, 4'd7, 1'b0},
    '{4'd2, 4'd4, 4'd6, 1'b1},
    '{4'd0, 4'd5, 4'd7, 1'b1},
    '{4'd1, 4'd3, 4'd8, 1'b1},
    '{4'd0, 4'd0, 4'd0, 1'b0},
    '{4'd0, 4'd0, 4'd0, 1'b0}
  };

  localparam term_t Term2 [2] = '{
    '{4'd0, 4'd4, OneIdx, 1'b0},
    '{4'd1, 4'd3, OneIdx, 1'b1}
  };

  function automatic int unsigned det_width(int unsigned w);
    return 3 * w + 3;
  endfunction

endpackage

// File: rtl/det_term_mul.sv
// Combinational signed triple product: term = (neg ? -1 : 1) * a * b * c, modulo 2^DW.
module det_term_mul
  import det_pkg::*;
#(
  parameter int unsigned DW = det_width(2)
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  input  logic          neg_i,
  output logic [DW-1:0] term_o
);

  logic [DW-1:0] prod;

  // Operands arrive already extended to DW, so the truncated product is exact.
  always_comb begin
    prod   = a_i * b_i * c_i;
    term_o = neg_i ? (DW'(0) - prod) : prod;
  end

endmodule

// File: rtl/determinant_seq.sv
// Sequential 2x2/3x3 determinant engine: one Leibniz term per cycle on a shared multiplier.
module determinant_seq
  import det_pkg::*;
#(
  parameter int unsigned W      = 2,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned DW     = det_width(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mode,
  input  logic [9*W-1:0]  mat_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   det
);

  state_e          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic            mode_q, mode_d;
  logic [9*W-1:0]  mat_q, mat_d;
  logic [DW-1:0]   acc_q, acc_d;

  logic [DW-1:0]   elem [16];
  term_t           term;
  logic [DW-1:0]   term_val;
  logic [2:0]      k_last;

  function automatic logic [DW-1:0] ext(logic [W-1:0] v);
    if (SIGNED) begin
      return {{(DW-W){v[W-1]}}, v};
    end else begin
      return {{(DW-W){1'b0}}, v};
    end
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      elem[i] = ext(mat_q[i*W +: W]);
    end
    elem[9] = DW'(1);
    for (int i = 10; i < 16; i++) begin
      elem[i] = '0;
    end
  end

  always_comb begin
    term   = mode_q ? Term3[k_q] : Term2[k_q[0]];
    k_last = mode_q ? 3'(N3 - 1) : 3'(N2 - 1);
  end

  det_term_mul #(
    .DW (DW)
  ) u_term_mul (
    .a_i    (elem[term.x]),
    .b_i    (elem[term.y]),
    .c_i    (elem[term.z]),
    .neg_i  (term.neg),
    .term_o (term_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      mode_q  <= 1'b0;
      mat_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      mat_q   <= mat_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    mode_d    = mode_q;
    mat_d     = mat_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mat_d   = mat_in;
          mode_d  = mode;
          acc_d   = '0;
          k_d     = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_q + term_val;
        if (k_q == k_last) begin
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The accumulator is the result register; it holds the last value while idle.
  assign det = acc_q;

endmodule
